// File: rtl/neurram_spi_shifter.sv
// Serial engine for the NeuRRAM shift-register chains: loads parallel words, shifts them MSB-first
// on a divided SPI clock and returns the bits captured from the chain as parallel words.
module neurram_spi_shifter #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_trigger,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              spi_data_out,
  input  logic              spi_data_in,
  output logic              state_spi_clk,
  output logic              state_spi_idle,
  output logic              done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int WRD_W = $clog2(NUM_WORDS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [WRD_W-1:0] WRD_LAST = WRD_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SLOW,
    S_SHIGH,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [WRD_W-1:0]  word_cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic              din_ready_q;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              spi_data_out_q;
  logic              spi_clk_q;
  logic              spi_idle_q;
  logic              done_q;

  // Shift-in value for the end of a high phase; a 1-bit word is simply replaced.
  generate
    if (DATA_W == 1) begin : g_shift_w1
      assign shreg_d = spi_data_in;
    end else begin : g_shift_wn
      assign shreg_d = {shreg_q[DATA_W-2:0], spi_data_in};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      word_cnt_q     <= '0;
      shreg_q        <= '0;
      din_ready_q    <= 1'b0;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
      spi_data_out_q <= 1'b0;
      spi_clk_q      <= 1'b0;
      spi_idle_q     <= 1'b1;
      done_q         <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          spi_clk_q  <= 1'b0;
          spi_idle_q <= 1'b1;
          if (spi_trigger) begin
            state_q     <= S_LOAD;
            spi_idle_q  <= 1'b0;
            din_ready_q <= 1'b1;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
          end
        end

        // Arriving here after a finished word, din_ready is raised one cycle late so it
        // never coincides with that word's dout_valid pulse.
        S_LOAD: begin
          spi_clk_q <= 1'b0;
          if (!din_ready_q) begin
            din_ready_q <= 1'b1;
          end else if (din_valid) begin
            shreg_q        <= din;
            bit_cnt_q      <= '0;
            div_cnt_q      <= '0;
            din_ready_q    <= 1'b0;
            spi_data_out_q <= din[DATA_W-1];
            state_q        <= S_SLOW;
          end
        end

        S_SLOW: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            spi_clk_q <= 1'b1;
            state_q   <= S_SHIGH;
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end

        S_SHIGH: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            spi_clk_q <= 1'b0;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q != BIT_LAST) begin
              // Next bit goes out together with the falling SPI clock edge.
              spi_data_out_q <= shreg_d[DATA_W-1];
              state_q        <= S_SLOW;
            end else begin
              dout_q       <= shreg_d;
              dout_valid_q <= 1'b1;
              word_cnt_q   <= word_cnt_q + WRD_W'(1);
              state_q      <= (word_cnt_q != WRD_LAST) ? S_LOAD : S_DONE;
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end

        S_DONE: begin
          done_q      <= 1'b1;
          spi_idle_q  <= 1'b1;
          spi_clk_q   <= 1'b0;
          din_ready_q <= 1'b0;
          div_cnt_q   <= '0;
          bit_cnt_q   <= '0;
          word_cnt_q  <= '0;
          state_q     <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign din_ready      = din_ready_q;
  assign dout           = dout_q;
  assign dout_valid     = dout_valid_q;
  assign spi_data_out   = spi_data_out_q;
  assign state_spi_clk  = spi_clk_q;
  assign state_spi_idle = spi_idle_q;
  assign done           = done_q;

endmodule
